// File: rtl/lsu.sv
// Load/store unit driving the data port of the byte-addressed simulation memory.
// Optional build macro: LSU_ALIGN_CHECK_EN faults misaligned half/word/double accesses.
module lsu #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_be_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [63:0] mem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [3:0]  req_size;
    logic [64:0] req_end;
    logic        req_illegal;
    logic        req_range_err;
    logic        req_misaligned;
    logic        req_err;
    logic [7:0]  be;
    logic [63:0] size_mask;
    logic [63:0] load_ext;

    // End address at 65 bits so addresses near 2^64 cannot wrap past the check.
    always_comb begin
        req_size      = 4'd1 << req_funct3_i[1:0];
        req_end       = {1'b0, req_addr_i} + {61'd0, req_size};
        req_illegal   = req_we_i ? req_funct3_i[2] : (req_funct3_i == 3'b111);
        req_range_err = req_end > 65'(MEM_BYTES);
`ifdef LSU_ALIGN_CHECK_EN
        case (req_funct3_i[1:0])
            2'd1:    req_misaligned = req_addr_i[0];
            2'd2:    req_misaligned = |req_addr_i[1:0];
            2'd3:    req_misaligned = |req_addr_i[2:0];
            default: req_misaligned = 1'b0;
        endcase
`else
        req_misaligned = 1'b0;
`endif
        req_err = req_illegal | req_range_err | req_misaligned;
    end

    always_comb begin
        case (funct3_q[1:0])
            2'd0:    be = 8'h01;
            2'd1:    be = 8'h03;
            2'd2:    be = 8'h0F;
            default: be = 8'hFF;
        endcase
        size_mask = '0;
        for (int i = 0; i < 8; i++) begin
            size_mask[8*i +: 8] = {8{be[i]}};
        end
    end

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{56{mem_rdata_i[7]}}, mem_rdata_i[7:0]};
            3'b001:  load_ext = {{48{mem_rdata_i[15]}}, mem_rdata_i[15:0]};
            3'b010:  load_ext = {{32{mem_rdata_i[31]}}, mem_rdata_i[31:0]};
            3'b011:  load_ext = mem_rdata_i;
            3'b100:  load_ext = {56'd0, mem_rdata_i[7:0]};
            3'b101:  load_ext = {48'd0, mem_rdata_i[15:0]};
            3'b110:  load_ext = {32'd0, mem_rdata_i[31:0]};
            default: load_ext = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    rdata_d  = '0;
                    err_d    = req_err;
                    state_d  = req_err ? StResp : StAccess;
                end
            end
            StAccess: begin
                rdata_d = we_q ? 64'd0 : load_ext;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        rsp_err_o   = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            StIdle: req_ready_o = 1'b1;
            StAccess: begin
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_be_o    = be;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q & size_mask;
            end
            StResp: begin
                rsp_valid_o = 1'b1;
                rsp_rdata_o = rdata_q;
                rsp_err_o   = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule
